// File: rtl/dcache_controller_pkg.sv
// Shared types and constants for the dcache controller: FSM state encoding,
// CPU address field positions and the SRAM tag bit layout.
package dcache_controller_pkg;

  localparam int IDX_W  = 4;
  localparam int TAG_W  = 23;
  localparam int LINE_W = 256;
  localparam int OFS_W  = 5;

  localparam int WORD_W = 32;
  localparam int WORDS  = LINE_W / WORD_W;
  localparam int WSEL_W = 3;
  localparam int STAG_W = TAG_W + 2;

  // CPU byte address fields: tag=[31:9], index=[8:5], word=[4:2]
  localparam int TAG_MSB  = 31;
  localparam int TAG_LSB  = 9;
  localparam int IDX_LSB  = 5;
  localparam int WORD_LSB = 2;

  // SRAM tag word layout {valid, dirty, tag}
  localparam int VALID_BIT = 24;
  localparam int DIRTY_BIT = 23;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_MISS        = 3'd1,
    ST_WRITE_BACK  = 3'd2,
    ST_MEM_READ    = 3'd3,
    ST_READMISS_OK = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_controller_if.sv
// Bundle of the CPU, SRAM and data-memory signals around the controller.
// The master modport is the controller; the slave modport is everything
// around it (CPU MEM stage, SRAM, data memory).
interface dcache_controller_if;
  import dcache_controller_pkg::*;

  // CPU MEM stage
  logic [31:0]       cpu_addr_i;
  logic [31:0]       cpu_data_i;
  logic              cpu_MemRead_i;
  logic              cpu_MemWrite_i;
  logic [31:0]       cpu_data_o;
  logic              cpu_stall_o;

  // dcache SRAM
  logic [IDX_W-1:0]  sram_addr_o;
  logic [STAG_W-1:0] sram_tag_o;
  logic [LINE_W-1:0] sram_data_o;
  logic              sram_enable_o;
  logic              sram_write_o;
  logic [STAG_W-1:0] sram_tag_i;
  logic [LINE_W-1:0] sram_data_i;
  logic              sram_hit_i;

  // data memory
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;

  modport master (
    input  cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    output cpu_data_o, cpu_stall_o,
    output sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    input  sram_tag_i, sram_data_i, sram_hit_i,
    output mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output cpu_addr_i, cpu_data_i, cpu_MemRead_i, cpu_MemWrite_i,
    input  cpu_data_o, cpu_stall_o,
    input  sram_addr_o, sram_tag_o, sram_data_o, sram_enable_o, sram_write_o,
    output sram_tag_i, sram_data_i, sram_hit_i,
    input  mem_addr_o, mem_data_o, mem_enable_o, mem_write_o,
    output mem_data_i, mem_ack_i
  );

endinterface

// File: rtl/dcache_word_merge.sv
// Combinational 32-bit word access into a 256-bit line: extracts the
// selected word (load path) and builds the line with that word replaced
// (store path).
module dcache_word_merge
  import dcache_controller_pkg::*;
(
  input  logic [LINE_W-1:0] i_line,
  input  logic [WSEL_W-1:0] i_word_sel,
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word,
  output logic [LINE_W-1:0] o_line
);

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_slot
      assign o_line[gi*WORD_W +: WORD_W] =
        (i_word_sel == WSEL_W'(gi)) ? i_word : i_line[gi*WORD_W +: WORD_W];
    end
  endgenerate

  assign o_word = i_line[{i_word_sel, 5'd0} +: WORD_W];

endmodule

// File: rtl/dcache_controller.sv
// Data cache controller: serves load/store hits combinationally from the
// 2-way SRAM, and on a miss writes back a dirty victim, refills the line
// from data memory and stalls the CPU until the access hits.
module dcache_controller
  import dcache_controller_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_controller_if.master bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic              r_mem_enable;
  logic              r_mem_write;
  logic [31:0]       r_mem_addr;
  logic [LINE_W-1:0] r_mem_data;
  logic              w_mem_enable_next;
  logic              w_mem_write_next;
  logic [31:0]       w_mem_addr_next;
  logic [LINE_W-1:0] w_mem_data_next;

  logic              w_req;
  logic              w_is_store;
  logic [TAG_W-1:0]  w_cpu_tag;
  logic [IDX_W-1:0]  w_index;
  logic [WSEL_W-1:0] w_word_sel;
  logic              w_victim_dirty;
  logic [31:0]       w_victim_addr;
  logic [31:0]       w_refill_addr;
  logic [WORD_W-1:0] w_load_word;
  logic [LINE_W-1:0] w_store_line;
  logic              w_in_miss;
  logic              w_unused_ofs;

  assign w_req        = bus.cpu_MemRead_i | bus.cpu_MemWrite_i;
  assign w_is_store   = bus.cpu_MemWrite_i;
  assign w_cpu_tag    = bus.cpu_addr_i[TAG_MSB:TAG_LSB];
  assign w_index      = bus.cpu_addr_i[IDX_LSB +: IDX_W];
  assign w_word_sel   = bus.cpu_addr_i[WORD_LSB +: WSEL_W];
  assign w_unused_ofs = ^bus.cpu_addr_i[1:0];

  // The SRAM presents the LRU victim on a miss, so its tag says whether the
  // line must be written back before the refill.
  assign w_victim_dirty = bus.sram_tag_i[VALID_BIT] & bus.sram_tag_i[DIRTY_BIT];
  assign w_victim_addr  = {bus.sram_tag_i[TAG_W-1:0], w_index, {OFS_W{1'b0}}};
  assign w_refill_addr  = {w_cpu_tag, w_index, {OFS_W{1'b0}}};

  assign bus.sram_addr_o   = w_index;
  assign bus.sram_enable_o = w_req & ~rst_i;

  dcache_word_merge u_word_merge (
    .i_line     (bus.sram_data_i),
    .i_word_sel (w_word_sel),
    .i_word     (bus.cpu_data_i),
    .o_word     (w_load_word),
    .o_line     (w_store_line)
  );

  // The memory request starts in the MISS cycle itself, so the values being
  // loaded into the request registers are shown directly during MISS.
  assign w_in_miss        = (r_state == ST_MISS) & ~rst_i;
  assign bus.mem_enable_o = w_in_miss ? w_mem_enable_next : r_mem_enable;
  assign bus.mem_write_o  = w_in_miss ? w_mem_write_next  : r_mem_write;
  assign bus.mem_addr_o   = w_in_miss ? w_mem_addr_next   : r_mem_addr;
  assign bus.mem_data_o   = w_in_miss ? w_mem_data_next   : r_mem_data;

  // Next-state, memory-request and CPU/SRAM output decode
  always_comb begin
    w_state_next      = r_state;
    w_mem_enable_next = r_mem_enable;
    w_mem_write_next  = r_mem_write;
    w_mem_addr_next   = r_mem_addr;
    w_mem_data_next   = r_mem_data;
    bus.cpu_data_o    = '0;
    bus.cpu_stall_o   = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_data_o   = '0;
    bus.sram_tag_o    = '0;

    case (r_state)
      ST_IDLE: begin
        bus.cpu_stall_o = w_req & ~bus.sram_hit_i;
        if (w_req && bus.sram_hit_i) begin
          if (w_is_store) begin
            bus.sram_write_o = 1'b1;
            bus.sram_data_o  = w_store_line;
            bus.sram_tag_o   = {1'b1, 1'b1, w_cpu_tag};
          end else begin
            bus.cpu_data_o = w_load_word;
          end
        end else if (w_req) begin
          w_state_next = ST_MISS;
        end
      end

      ST_MISS: begin
        bus.cpu_stall_o   = 1'b1;
        w_mem_enable_next = 1'b1;
        if (w_victim_dirty) begin
          w_mem_addr_next  = w_victim_addr;
          w_mem_data_next  = bus.sram_data_i;
          w_mem_write_next = 1'b1;
          w_state_next     = ST_WRITE_BACK;
        end else begin
          w_mem_addr_next  = w_refill_addr;
          w_mem_data_next  = '0;
          w_mem_write_next = 1'b0;
          w_state_next     = ST_MEM_READ;
        end
      end

      ST_WRITE_BACK: begin
        bus.cpu_stall_o = 1'b1;
        if (bus.mem_ack_i) begin
          w_mem_addr_next  = w_refill_addr;
          w_mem_data_next  = '0;
          w_mem_write_next = 1'b0;
          w_state_next     = ST_MEM_READ;
        end
      end

      ST_MEM_READ: begin
        bus.cpu_stall_o = 1'b1;
        if (bus.mem_ack_i) begin
          // Refilled line lands clean; a pending store merges on the next hit.
          bus.sram_write_o  = 1'b1;
          bus.sram_data_o   = bus.mem_data_i;
          bus.sram_tag_o    = {1'b1, 1'b0, w_cpu_tag};
          w_mem_enable_next = 1'b0;
          w_mem_write_next  = 1'b0;
          w_mem_addr_next   = '0;
          w_mem_data_next   = '0;
          w_state_next      = ST_READMISS_OK;
        end
      end

      ST_READMISS_OK: begin
        bus.cpu_stall_o = 1'b1;
        w_state_next    = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (rst_i) begin
      w_state_next     = ST_IDLE;
      bus.cpu_data_o   = '0;
      bus.cpu_stall_o  = 1'b0;
      bus.sram_write_o = 1'b0;
      bus.sram_data_o  = '0;
      bus.sram_tag_o   = '0;
    end
  end

  // State and memory-request registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_mem_enable <= w_mem_enable_next;
      r_mem_write  <= w_mem_write_next;
      r_mem_addr   <= w_mem_addr_next;
      r_mem_data   <= w_mem_data_next;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: a 2-way LRU SRAM and a data memory with
// programmable ack latency surround the DUT; a flat word-memory plus
// per-set MRU-ordered residency model predicts load data, stall length
// and write-back traffic.
module tb_dcache_controller;
  import dcache_controller_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  dcache_controller_if bus ();

  dcache_controller dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- SRAM environment (2 ways, LRU) ----------------
  logic [24:0]  s_tag  [16][2] = '{default: '0};
  logic [255:0] s_data [16][2] = '{default: '0};
  logic         s_lru  [16]    = '{default: 1'b0};
  logic [3:0]   s_idx;
  logic         s_hit;
  logic         s_way;

  always_comb begin
    s_idx = bus.sram_addr_o;
    s_hit = 1'b0;
    s_way = s_lru[s_idx];
    for (int w = 0; w < 2; w++) begin
      if (s_tag[s_idx][w][24] && s_tag[s_idx][w][22:0] == bus.cpu_addr_i[31:9]) begin
        s_hit = 1'b1;
        s_way = 1'(w);
      end
    end
    bus.sram_hit_i  = s_hit;
    bus.sram_tag_i  = s_tag[s_idx][s_way];
    bus.sram_data_i = s_data[s_idx][s_way];
  end

  always @(posedge clk_i) begin
    if (bus.sram_enable_o) begin
      if (bus.sram_write_o) begin
        s_tag[s_idx][s_way]  <= bus.sram_tag_o;
        s_data[s_idx][s_way] <= bus.sram_data_o;
      end
      if (s_hit) s_lru[s_idx] <= ~s_way;
    end
  end

  // ---------------- data memory environment ----------------
  logic [255:0] dmem [64];
  int           mem_lat = 2;
  logic         resp_ack = 1'b0;
  logic         stray_ack = 1'b0;
  bit           busy = 1'b0;
  int           cnt = 0;
  int           wb_cnt = 0;
  int           rd_cnt = 0;
  logic [31:0]  last_wb_addr = '0;
  logic [31:0]  last_rd_addr = '0;

  assign bus.mem_ack_i = resp_ack | stray_ack;
  always_comb bus.mem_data_i = dmem[bus.mem_addr_o[10:5]];

  // Acks a request mem_lat cycles after the cycle it was first seen.
  initial begin
    for (int i = 0; i < 64; i++)
      dmem[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    dmem[8][31:0] = 32'h1111_1111;
    forever begin
      @(negedge clk_i);
      resp_ack = 1'b0;
      if (rst_i || !bus.mem_enable_o) begin
        busy = 1'b0;
        cnt  = 0;
      end else if (!busy) begin
        busy = 1'b1;
        cnt  = 0;
      end else begin
        cnt++;
        if (cnt >= mem_lat) begin
          resp_ack = 1'b1;
          busy     = 1'b0;
          if (bus.mem_write_o) begin
            wb_cnt++;
            last_wb_addr = bus.mem_addr_o;
            dmem[bus.mem_addr_o[10:5]] = bus.mem_data_o;
          end else begin
            rd_cnt++;
            last_rd_addr = bus.mem_addr_o;
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_word [512];
  logic [22:0] rtag   [16][2];
  bit          rval   [16][2];
  bit          rdirty [16][2];

  task automatic model_access(input logic [31:0] addr, input bit store, input logic [31:0] wdata,
                              output int exp_stall, output bit exp_miss, output bit exp_wb,
                              output logic [31:0] exp_wb_addr);
    int idx;
    logic [22:0] tag;
    bit d;
    idx = int'(addr[8:5]);
    tag = addr[31:9];
    exp_stall = 0; exp_miss = 0; exp_wb = 0; exp_wb_addr = '0;
    if (rval[idx][0] && rtag[idx][0] == tag) begin
      rdirty[idx][0] = rdirty[idx][0] | store;
    end else if (rval[idx][1] && rtag[idx][1] == tag) begin
      d = rdirty[idx][1];
      rtag[idx][1] = rtag[idx][0]; rval[idx][1] = rval[idx][0]; rdirty[idx][1] = rdirty[idx][0];
      rtag[idx][0] = tag; rval[idx][0] = 1'b1; rdirty[idx][0] = d | store;
    end else begin
      exp_miss    = 1'b1;
      exp_wb      = rval[idx][1] && rdirty[idx][1];
      exp_wb_addr = {rtag[idx][1], addr[8:5], 5'b0};
      exp_stall   = mem_lat + 3 + (exp_wb ? mem_lat + 1 : 0);
      rtag[idx][1] = rtag[idx][0]; rval[idx][1] = rval[idx][0]; rdirty[idx][1] = rdirty[idx][0];
      rtag[idx][0] = tag; rval[idx][0] = 1'b1; rdirty[idx][0] = store;
    end
    if (store) ref_word[addr[10:2]] = wdata;
  endtask

  // One CPU access, held until the stall drops; one line printed per access.
  task automatic access(input string name, input logic [31:0] addr, input bit rd, input bit wr,
                        input logic [31:0] wdata);
    int exp_stall, n, wb0, rd0;
    bit exp_miss, exp_wb, en_ok, refill_seen;
    logic [31:0] exp_wb_addr, exp_rd;
    logic [24:0] refill_tag;
    logic refill_wr;
    exp_rd = ref_word[addr[10:2]];
    model_access(addr, wr, wdata, exp_stall, exp_miss, exp_wb, exp_wb_addr);
    wb0 = wb_cnt; rd0 = rd_cnt;
    en_ok = 1'b1; refill_seen = 1'b0; refill_tag = '0; refill_wr = 1'b0;
    @(posedge clk_i); #1;
    bus.cpu_addr_i = addr; bus.cpu_data_i = wdata;
    bus.cpu_MemRead_i = rd; bus.cpu_MemWrite_i = wr;
    n = 0;
    forever begin
      @(negedge clk_i); #1;
      if (!bus.cpu_stall_o || n >= 400) break;
      if (n < exp_stall && bus.mem_enable_o !== (n != 0 && n != exp_stall - 1)) en_ok = 1'b0;
      if (bus.mem_ack_i && !bus.mem_write_o && !refill_seen) begin
        refill_seen = 1'b1;
        refill_tag  = bus.sram_tag_o;
        refill_wr   = bus.sram_write_o;
      end
      n++;
    end
    check({name, ":stall_cycles"}, n, exp_stall);
    if (wr) begin
      check({name, ":store_wr"}, bus.sram_write_o, 1'b1);
      check({name, ":store_tag"}, bus.sram_tag_o, {2'b11, addr[31:9]});
      check({name, ":store_cpu_data"}, bus.cpu_data_o, 32'h0);
    end else begin
      check({name, ":load_data"}, bus.cpu_data_o, exp_rd);
    end
    if (exp_miss) begin
      check({name, ":mem_en_profile"}, en_ok, 1'b1);
      check({name, ":refill_cnt"}, rd_cnt - rd0, 1);
      check({name, ":refill_addr"}, last_rd_addr, {addr[31:5], 5'b0});
      check({name, ":refill_tag"}, {refill_wr, refill_tag}, {1'b1, 2'b10, addr[31:9]});
      check({name, ":wb_cnt"}, wb_cnt - wb0, exp_wb ? 1 : 0);
      if (exp_wb) check({name, ":wb_addr"}, last_wb_addr, exp_wb_addr);
    end
    $display("access %-10s addr=%08h rd=%0b wr=%0b stall=%0d lat=%0d data_o=%08h", name, addr, rd, wr,
             n, mem_lat, bus.cpu_data_o);
    @(posedge clk_i); #1;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    int op;
    logic [31:0] a;
    bus.cpu_addr_i = 32'h100; bus.cpu_data_i = 32'h0;
    bus.cpu_MemRead_i = 1'b0; bus.cpu_MemWrite_i = 1'b1;
    for (int s = 0; s < 16; s++)
      for (int w = 0; w < 2; w++) begin
        rval[s][w] = 1'b0; rdirty[s][w] = 1'b0; rtag[s][w] = '0;
      end
    repeat (3) @(posedge clk_i);
    #1;
    for (int i = 0; i < 512; i++) ref_word[i] = dmem[i >> 3][(i % 8) * 32 +: 32];

    // reset holds everything quiet even with a request present
    check("rst:sram_en", bus.sram_enable_o, 1'b0);
    check("rst:stall", bus.cpu_stall_o, 1'b0);
    check("rst:sram_wr", bus.sram_write_o, 1'b0);
    check("rst:mem_en", bus.mem_enable_o, 1'b0);
    check("rst:cpu_data", bus.cpu_data_o, 32'h0);
    rst_i = 1'b0; bus.cpu_MemWrite_i = 1'b0;

    // directed: cold load, store hit, dirty fill of set 8, write-backs
    mem_lat = 2;
    access("cold_ld", 32'h0000_0100, 1, 0, 32'h0);
    check("cold_ld:word0", ref_word[64], 32'h1111_1111);
    access("st_hit", 32'h0000_0104, 0, 1, 32'hDEAD_BEEF);
    access("ld_hit", 32'h0000_0104, 1, 0, 32'h0);
    access("st_way1", 32'h0000_0300, 0, 1, 32'hCAFE_0001);
    access("st_evict", 32'h0000_0500, 0, 1, 32'hCAFE_0002);
    access("ld_back", 32'h0000_0104, 1, 0, 32'h0);

    // reset in the middle of a long refill
    mem_lat = 10;
    @(posedge clk_i); #1;
    bus.cpu_addr_i = 32'h0000_0040; bus.cpu_MemRead_i = 1'b1;
    repeat (5) @(negedge clk_i);
    #1;
    check("midrst:mem_en_before", bus.mem_enable_o, 1'b1);
    check("midrst:stall_before", bus.cpu_stall_o, 1'b1);
    rst_i = 1'b1;
    #1;
    check("midrst:stall_in_rst", bus.cpu_stall_o, 1'b0);
    check("midrst:sram_en_in_rst", bus.sram_enable_o, 1'b0);
    @(posedge clk_i); #1;
    check("midrst:mem_en_after", bus.mem_enable_o, 1'b0);
    check("midrst:mem_addr_after", bus.mem_addr_o, 32'h0);
    rst_i = 1'b0; bus.cpu_MemRead_i = 1'b0;
    stray_ack = 1'b1;
    @(posedge clk_i); #1;
    stray_ack = 1'b0;
    check("stray_ack:mem_en", bus.mem_enable_o, 1'b0);
    check("stray_ack:stall", bus.cpu_stall_o, 1'b0);
    access("rst_retry", 32'h0000_0040, 1, 0, 32'h0);

    // read and write together act as a store
    mem_lat = 3;
    access("rdwr_hit", 32'h0000_0048, 1, 1, 32'h5A5A_5A5A);
    access("rdwr_chk", 32'h0000_0048, 1, 0, 32'h0);

    // randomized traffic over 4 tags x 16 sets
    for (int t = 0; t < 80; t++) begin
      mem_lat = $urandom_range(1, 4);
      op = $urandom_range(0, 2);
      a = {21'b0, 11'($urandom_range(0, 2047))} & 32'hFFFF_FFFC;
      access($sformatf("rnd%0d", t), a, op != 1, op != 0, $urandom);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // overall time bound so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
FSM controller sitting directly upstream of the 2-way dcache SRAM (16 sets, 256-bit lines, 25-bit tag {valid, dirty, tag[22:0]}).
Accepts 32-bit word loads and stores from the CPU MEM stage and drives the SRAM index, tag, data, enable and write controls.
On a miss it writes back a dirty victim, refills the line from data memory over a 256-bit ack handshake, and stalls the CPU until the access hits.

Parameters:
IDX_W, 4, index width (16 sets)
TAG_W, 23, address tag width
LINE_W, 256, line width in bits
OFS_W, 5, byte offset width (32-byte line)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cpu_addr_i  in  32  byte address: tag=[31:9], index=[8:5], word=[4:2]; [1:0] ignored
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request
cpu_MemWrite_i  in  1  store request
cpu_data_o  out  32  load data
cpu_stall_o  out  1  CPU must hold its request and pipeline
sram_addr_o  out  4  SRAM index
sram_tag_o  out  25  tag to SRAM {valid, dirty, tag}
sram_data_o  out  256  line to SRAM
sram_enable_o  out  1  SRAM access
sram_write_o  out  1  SRAM write
sram_tag_i  in  25  hit way tag, or LRU victim tag on a miss
sram_data_i  in  256  hit way line, or LRU victim line on a miss
sram_hit_i  in  1  SRAM hit
mem_addr_o  out  32  line-aligned memory address ([4:0]=0)
mem_data_o  out  256  write-back line
mem_enable_o  out  1  memory request
mem_write_o  out  1  1 = write-back, 0 = refill read
mem_data_i  in  256  refill line
mem_ack_i  in  1  one-cycle completion pulse from memory

Behaviour:
- Interface is fixed: one clock clk_i; reset rst_i is synchronous and active-high.
- req = cpu_MemRead_i | cpu_MemWrite_i. If both are high, the access is treated as a store.
- sram_addr_o = cpu_addr_i[8:5] at all times.
- sram_enable_o = req, outside of reset.
- States:
  - IDLE: hit path is combinational, 0 extra cycles. cpu_stall_o = req & ~sram_hit_i.
  - IDLE, load hit: cpu_data_o = sram_data_i[32*word +: 32]. Otherwise cpu_data_o = 0.
  - IDLE, store hit: sram_write_o=1; sram_data_o = sram_data_i with word slot replaced by cpu_data_i; sram_tag_o = {1,1,cpu tag}. Committed at the clock edge.
  - IDLE, req & miss: next state MISS.
  - MISS: victim dirty (sram_tag_i[24]&sram_tag_i[23]) -> mem_addr_o={sram_tag_i[22:0], index, 5'b0}, mem_data_o=sram_data_i, mem_write_o=1, next WRITE_BACK.
  - MISS: victim not dirty -> mem_addr_o={cpu tag, index, 5'b0}, mem_write_o=0, next MEM_READ.
  - MISS: mem_enable_o=1.
  - WRITE_BACK: mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are held from registers.
  - WRITE_BACK, on mem_ack_i: next MEM_READ. Refill address registered; mem_write_o=0.
  - MEM_READ: mem_enable_o=1, mem_write_o=0.
  - MEM_READ, on mem_ack_i (same cycle): sram_write_o=1, sram_data_o=mem_data_i, sram_tag_o={1,0,cpu tag}; next READMISS_OK.
  - READMISS_OK: mem_enable_o=0, no SRAM write; next IDLE. The access then hits in IDLE (store merges there and sets dirty).
- cpu_stall_o=1 in every non-IDLE state.
- mem_enable_o is level-held from the MISS cycle through the ack cycle, inclusive. mem_ack_i outside WRITE_BACK/MEM_READ is ignored.
- Miss penalty: clean victim = 1 (MISS) + memory latency + 1 (READMISS_OK) + 1 (hit) cycles. Dirty victim adds one full memory transaction.
- The CPU holds cpu_addr_i, cpu_data_i and the request stable while stalled. The controller does not re-check the tag after refill.
- Reset, including mid-transaction: state=IDLE.
  - All registered outputs 0 (mem_enable_o, mem_write_o, mem_addr_o, mem_data_o).
  - While rst_i is high: sram_enable_o=0, sram_write_o=0, cpu_stall_o=0, cpu_data_o=0.
  - An outstanding memory ack after reset is ignored.
- Only the SRAM owns LRU; the controller never selects a way.

Decomposition:
- Shared package: state encoding (IDLE, MISS, WRITE_BACK, MEM_READ, READMISS_OK), and address field slice constants (TAG_MSB=31, TAG_LSB=9, IDX_LSB=5, WORD_LSB=2).
- Shared package: tag bit positions (VALID_BIT=24, DIRTY_BIT=23).
- One sub-module: dcache_word_merge (combinational 32-bit word select/insert into a 256-bit line), reused for both the load mux and the store merge.

Test Plan:
- Cold load from 0x0000_0100 with memory line word0=0x1111_1111 -> stall; MEM_READ mem_addr_o=0x0000_0100; SRAM written tag {1,0,0x000000}; then cpu_data_o=0x1111_1111 with stall low.
- Store 0xDEAD_BEEF to 0x0000_0104 after that refill -> 0 stall cycles; sram_tag_o={1,1,0}; word1 updated; a later load returns 0xDEAD_BEEF.
- Fill both ways of index 8 (dirty), then access a third tag -> WRITE_BACK with mem_addr_o of the LRU victim and mem_write_o=1; after ack, MEM_READ with the new tag.
- Memory ack delayed 10 cycles -> mem_enable_o held high for all 10 cycles; cpu_stall_o high throughout.
- rst_i asserted during MEM_READ -> next cycle state IDLE, mem_enable_o=0; a stray mem_ack_i is ignored; the next access restarts the miss sequence.
- cpu_MemRead_i and cpu_MemWrite_i both high on a hit -> store performed and dirty bit set.
